pc_seq: RTL and testbench
=========================

PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 Parameter WIDTH, default 32: PC width in bits; legal range 28..64.
REQ-002 Parameter IMM_W, default 16: branch-offset width; must be less than WIDTH-2.
REQ-003 Parameter RAS_DEPTH, default 4: return-address-stack entries; power of two, at least 2.
REQ-004 Parameter RESET_PC, default 32'h0040_0000: PC value loaded by reset.
REQ-005 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-006 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 Port stall, input, 1 bit: when 1, hold all state.
REQ-008 Port nPC_sel, input, 2 bits: 00 SEQ, 01 BRANCH, 10 JUMP, 11 RETURN.
REQ-009 Port taken, input, 1 bit: branch condition; used only in BRANCH mode.
REQ-010 Port call, input, 1 bit: push link address; used only in JUMP mode.
REQ-011 Port imm, input, IMM_W bits: signed branch word offset.
REQ-012 Port jidx, input, 26 bits: jump word index.
REQ-013 Port pc, output, WIDTH bits: current PC (registered).
REQ-014 Port pc_plus4, output, WIDTH bits: pc+4 (combinational from pc).
REQ-015 Port ras_empty, output, 1 bit: 1 when the stack count is 0.
REQ-016 Port ras_full, output, 1 bit: 1 when the stack count equals RAS_DEPTH.
REQ-017 Port ras_err, output, 1 bit: sticky flag for underflow or overflow.

Function
REQ-018 pc_plus4 SHALL equal pc+4 modulo 2^WIDTH; wrap from all-ones-minus-3 to 0 is silent.
REQ-019 The branch target SHALL equal pc_plus4 + (sign-extended imm << 2), computed modulo 2^WIDTH.
REQ-020 The jump target SHALL equal {pc_plus4[WIDTH-1:28], jidx, 2'b00}.
REQ-021 When stall=0, the next pc SHALL be selected as follows:
  - SEQ: pc_plus4.
  - BRANCH, taken=1: branch target.
  - BRANCH, taken=0: pc_plus4.
  - JUMP: jump target.
  - RETURN, stack non-empty: top-of-stack.
  - RETURN, stack empty: pc_plus4.
REQ-022 JUMP with call=1 and stall=0 SHALL push pc_plus4 of the current cycle onto the stack.
REQ-023 A push when count<RAS_DEPTH SHALL increment count.
REQ-024 A push when full SHALL:
  - overwrite the oldest entry (circular);
  - leave count at RAS_DEPTH;
  - set ras_err.
REQ-025 RETURN with a non-empty stack SHALL pop the stack and decrement count.
REQ-026 RETURN with an empty stack SHALL leave count at 0 and set ras_err.
REQ-027 call SHALL be ignored outside JUMP; taken SHALL be ignored outside BRANCH.
REQ-028 When stall=1, pc, stack contents, count and ras_err SHALL all hold, regardless of other inputs.
REQ-029 Every new pc value SHALL appear on pc one cycle after the edge that selects it; there are no other pipeline stages.
REQ-030 ras_empty and ras_full SHALL be derived combinationally from the registered count.
REQ-031 ras_err SHALL clear only on reset.

Reset
REQ-032 When reset=1 at a rising edge, the block SHALL set pc=RESET_PC, count=0 and ras_err=0.
REQ-033 Reset SHALL take priority over stall and over every nPC_sel mode.
REQ-034 Stack entry contents are don't-care after reset and SHALL never be observable while count=0.
REQ-035 A reset asserted mid-sequence SHALL discard any pending push or pop in that cycle.
REQ-036 After reset, the outputs SHALL be: pc_plus4=RESET_PC+4, ras_empty=1, ras_full=0, ras_err=0.

Verification
REQ-037 Reset then SEQ for 3 cycles -> pc = 0x00400000, 0x00400004, 0x00400008, 0x0040000C.
REQ-038 From pc=0x00400010, apply BRANCH with taken=1 and imm=16'hFFFC -> pc=0x00400004. Then BRANCH with taken=0 -> pc=0x00400008.
REQ-039 From pc=0x00400020, apply JUMP with call=1 and jidx=26'h0100040 -> pc=0x00400100. Then RETURN -> pc=0x00400024, ras_empty=1, ras_err=0.
REQ-040 Five JUMP+call pushes with RAS_DEPTH=4 -> ras_full=1 and ras_err=1. Four RETURNs then yield the link addresses of pushes 5, 4, 3, 2; a fifth RETURN gives pc_plus4 with ras_empty=1.
REQ-041 stall=1 held for 3 cycles while nPC_sel=RETURN and the stack is non-empty -> pc and count unchanged. Asserting reset together with stall -> pc=0x00400000, count=0.
REQ-042 From pc=32'hFFFFFFFC, apply SEQ -> pc=0, with no error flagged.

Source files
------------

// File: rtl/pc_seq.sv
// rtl/pc_seq.sv - program-counter sequencer with branch/jump targets and a return-address stack.
// The stack is circular: a push onto a full stack overwrites the oldest entry and flags ras_err.
module pc_seq #(
   parameter int WIDTH     = 32,
   parameter int IMM_W     = 16,
   parameter int RAS_DEPTH = 4,
   parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h0040_0000)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic [1:0]       nPC_sel,
   input  logic             taken,
   input  logic             call,
   input  logic [IMM_W-1:0] imm,
   input  logic [25:0]      jidx,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_plus4,
   output logic             ras_empty,
   output logic             ras_full,
   output logic             ras_err
);

   localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int CNT_W = $clog2(RAS_DEPTH + 1);

   typedef enum logic [1:0] {
      SEL_SEQ    = 2'b00,
      SEL_BRANCH = 2'b01,
      SEL_JUMP   = 2'b10,
      SEL_RETURN = 2'b11
   } sel_e;

   logic [WIDTH-1:0] pc_q, pc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PTR_W-1:0] sp_q, sp_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] ras_q [RAS_DEPTH];
   logic [WIDTH-1:0] ras_d [RAS_DEPTH];

   sel_e             sel;
   logic [WIDTH-1:0] br_tgt;
   logic [WIDTH-1:0] jmp_tgt;
   logic [PTR_W-1:0] sp_dec;
   logic             empty;
   logic             full;

   assign sel      = sel_e'(nPC_sel);
   assign pc_plus4 = pc_q + WIDTH'(4);
   assign br_tgt   = pc_plus4 + {{(WIDTH-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
   assign sp_dec   = sp_q - PTR_W'(1);
   assign empty    = (cnt_q == '0);
   assign full     = (cnt_q == CNT_W'(RAS_DEPTH));

   // With exactly 28 bits there are no upper region bits to carry over from pc_plus4.
   generate
      if (WIDTH > 28) begin : g_jmp_hi
         assign jmp_tgt = {pc_plus4[WIDTH-1:28], jidx, 2'b00};
      end else begin : g_jmp_lo
         assign jmp_tgt = {jidx, 2'b00};
      end
   endgenerate

   always_comb begin
      pc_d  = pc_q;
      cnt_d = cnt_q;
      sp_d  = sp_q;
      err_d = err_q;
      ras_d = ras_q;
      if (!stall) begin
         case (sel)
            SEL_SEQ: pc_d = pc_plus4;
            SEL_BRANCH: pc_d = taken ? br_tgt : pc_plus4;
            SEL_JUMP: begin
               pc_d = jmp_tgt;
               if (call) begin
                  // sp_q always names the slot after the top, which is the oldest entry when full.
                  ras_d[sp_q] = pc_plus4;
                  sp_d        = sp_q + PTR_W'(1);
                  if (full) err_d = 1'b1;
                  else      cnt_d = cnt_q + CNT_W'(1);
               end
            end
            SEL_RETURN: begin
               if (empty) begin
                  pc_d  = pc_plus4;
                  err_d = 1'b1;
               end else begin
                  pc_d  = ras_q[sp_dec];
                  sp_d  = sp_dec;
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            default: pc_d = pc_plus4;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q  <= RESET_PC;
         cnt_q <= '0;
         sp_q  <= '0;
         err_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         cnt_q <= cnt_d;
         sp_q  <= sp_d;
         err_q <= err_d;
         ras_q <= ras_d;
      end
   end

   assign pc        = pc_q;
   assign ras_empty = empty;
   assign ras_full  = full;
   assign ras_err   = err_q;

endmodule

// File: tb/tb_pc_seq.sv
// tb/tb_pc_seq.sv - table-driven scoreboard bench for pc_seq.
module tb_pc_seq;

   localparam logic [1:0] SEQ = 2'b00, BR = 2'b01, JMP = 2'b10, RET = 2'b11;

   typedef struct {
      logic        rst;
      logic        stl;
      logic [1:0]  sel;
      logic        tk;
      logic        cl;
      logic [15:0] im;
      logic [25:0] ji;
      logic [31:0] e_pc;
      logic        e_empty;
      logic        e_full;
      logic        e_err;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset, stall, taken, call;
   logic [1:0]  nPC_sel;
   logic [15:0] imm;
   logic [25:0] jidx;
   logic [31:0] pc, pc_plus4;
   logic        ras_empty, ras_full, ras_err;

   int n_vec  = 0;
   int n_miss = 0;
   vec_t vecs[$];
   vec_t exp_q[$];

   pc_seq dut (
      .clk(clk), .reset(reset), .stall(stall), .nPC_sel(nPC_sel), .taken(taken),
      .call(call), .imm(imm), .jidx(jidx), .pc(pc), .pc_plus4(pc_plus4),
      .ras_empty(ras_empty), .ras_full(ras_full), .ras_err(ras_err)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic r, input logic s, input logic [1:0] sl,
                               input logic t, input logic c, input logic [15:0] i,
                               input logic [25:0] j, input logic [31:0] p,
                               input logic e, input logic f, input logic er);
      vec_t v;
      v.rst = r; v.stl = s; v.sel = sl; v.tk = t; v.cl = c; v.im = i; v.ji = j;
      v.e_pc = p; v.e_empty = e; v.e_full = f; v.e_err = er;
      return v;
   endfunction

   task automatic check_one(input int idx);
      vec_t x;
      logic [31:0] e_p4;
      if (exp_q.size() == 0) begin
         n_miss++;
         $display("FAIL vec%0d scoreboard: no expected entry queued", idx);
         return;
      end
      x = exp_q.pop_front();
      e_p4 = x.e_pc + 32'd4;
      if (pc !== x.e_pc) begin
         n_miss++;
         $display("FAIL vec%0d pc: got %h want %h", idx, pc, x.e_pc);
      end
      if (pc_plus4 !== e_p4) begin
         n_miss++;
         $display("FAIL vec%0d pc_plus4: got %h want %h", idx, pc_plus4, e_p4);
      end
      if (ras_empty !== x.e_empty) begin
         n_miss++;
         $display("FAIL vec%0d ras_empty: got %b want %b", idx, ras_empty, x.e_empty);
      end
      if (ras_full !== x.e_full) begin
         n_miss++;
         $display("FAIL vec%0d ras_full: got %b want %b", idx, ras_full, x.e_full);
      end
      if (ras_err !== x.e_err) begin
         n_miss++;
         $display("FAIL vec%0d ras_err: got %b want %b", idx, ras_err, x.e_err);
      end
   endtask

   task automatic apply(input vec_t v, input int idx);
      @(negedge clk);
      reset = v.rst; stall = v.stl; nPC_sel = v.sel; taken = v.tk;
      call = v.cl; imm = v.im; jidx = v.ji;
      exp_q.push_back(v);
      n_vec++;
      @(posedge clk);
      #1;
      check_one(idx);
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; nPC_sel = SEQ; taken = 1'b0; call = 1'b0;
      imm = '0; jidx = '0;

      //           rst  stl  sel  tk   cl   imm       jidx        pc            E    F    R
      vecs.push_back(mk(1, 0, SEQ, 0, 0, 16'h0000, 26'h0,       32'h0040_0000, 1, 0, 0));
      vecs.push_back(mk(0, 0, SEQ, 0, 0, 16'h0000, 26'h0,       32'h0040_0004, 1, 0, 0));
      vecs.push_back(mk(0, 0, SEQ, 0, 0, 16'h0000, 26'h0,       32'h0040_0008, 1, 0, 0));
      vecs.push_back(mk(0, 0, SEQ, 0, 0, 16'h0000, 26'h0,       32'h0040_000C, 1, 0, 0));
      vecs.push_back(mk(0, 0, SEQ, 0, 0, 16'h0000, 26'h0,       32'h0040_0010, 1, 0, 0));
      vecs.push_back(mk(0, 0, BR,  1, 0, 16'hFFFC, 26'h0,       32'h0040_0004, 1, 0, 0));
      vecs.push_back(mk(0, 0, BR,  0, 0, 16'hFFFC, 26'h0,       32'h0040_0008, 1, 0, 0));
      vecs.push_back(mk(0, 0, BR,  1, 0, 16'h0005, 26'h0,       32'h0040_0020, 1, 0, 0));
      vecs.push_back(mk(0, 0, JMP, 0, 1, 16'h0000, 26'h0100040, 32'h0040_0100, 0, 0, 0));
      vecs.push_back(mk(0, 0, RET, 0, 0, 16'h0000, 26'h0,       32'h0040_0024, 1, 0, 0));
      vecs.push_back(mk(0, 0, SEQ, 1, 1, 16'h0040, 26'h0,       32'h0040_0028, 1, 0, 0));
      vecs.push_back(mk(0, 0, SEQ, 1, 0, 16'h0100, 26'h0,       32'h0040_002C, 1, 0, 0));
      vecs.push_back(mk(0, 0, JMP, 0, 1, 16'h0000, 26'h0140000, 32'h0050_0000, 0, 0, 0));
      vecs.push_back(mk(0, 0, JMP, 0, 1, 16'h0000, 26'h0180000, 32'h0060_0000, 0, 0, 0));
      vecs.push_back(mk(0, 0, JMP, 0, 1, 16'h0000, 26'h01C0000, 32'h0070_0000, 0, 0, 0));
      vecs.push_back(mk(0, 0, JMP, 0, 1, 16'h0000, 26'h0200000, 32'h0080_0000, 0, 1, 0));
      vecs.push_back(mk(0, 0, JMP, 0, 1, 16'h0000, 26'h0240000, 32'h0090_0000, 0, 1, 1));
      vecs.push_back(mk(0, 1, RET, 0, 0, 16'h0000, 26'h0,       32'h0090_0000, 0, 1, 1));
      vecs.push_back(mk(0, 1, JMP, 1, 1, 16'h0001, 26'h0010000, 32'h0090_0000, 0, 1, 1));
      vecs.push_back(mk(0, 1, RET, 0, 0, 16'h0000, 26'h0,       32'h0090_0000, 0, 1, 1));
      vecs.push_back(mk(0, 0, RET, 0, 0, 16'h0000, 26'h0,       32'h0080_0004, 0, 0, 1));
      vecs.push_back(mk(0, 0, RET, 0, 0, 16'h0000, 26'h0,       32'h0070_0004, 0, 0, 1));
      vecs.push_back(mk(0, 0, RET, 0, 0, 16'h0000, 26'h0,       32'h0060_0004, 0, 0, 1));
      vecs.push_back(mk(0, 0, RET, 0, 0, 16'h0000, 26'h0,       32'h0050_0004, 1, 0, 1));
      vecs.push_back(mk(0, 0, RET, 0, 0, 16'h0000, 26'h0,       32'h0050_0008, 1, 0, 1));
      vecs.push_back(mk(0, 0, JMP, 0, 1, 16'h0000, 26'h0280000, 32'h00A0_0000, 0, 0, 1));
      vecs.push_back(mk(1, 1, RET, 0, 0, 16'h0000, 26'h0,       32'h0040_0000, 1, 0, 0));
      vecs.push_back(mk(0, 0, JMP, 0, 1, 16'h0000, 26'h02C0000, 32'h00B0_0000, 0, 0, 0));
      vecs.push_back(mk(1, 0, RET, 0, 0, 16'h0000, 26'h0,       32'h0040_0000, 1, 0, 0));
      vecs.push_back(mk(0, 0, RET, 0, 0, 16'h0000, 26'h0,       32'h0040_0004, 1, 0, 1));
      vecs.push_back(mk(1, 0, JMP, 0, 1, 16'h0000, 26'h0300000, 32'h0040_0000, 1, 0, 0));
      vecs.push_back(mk(0, 0, JMP, 0, 0, 16'h0000, 26'h0,       32'h0000_0000, 1, 0, 0));
      vecs.push_back(mk(0, 0, BR,  1, 0, 16'hFFFE, 26'h0,       32'hFFFF_FFFC, 1, 0, 0));
      vecs.push_back(mk(0, 0, SEQ, 0, 0, 16'h0000, 26'h0,       32'h0000_0000, 1, 0, 0));

      for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

      // Nested calls interleaved with sequential and branch steps.
      apply(mk(1, 0, SEQ, 0, 0, 16'h0000, 26'h0,       32'h0040_0000, 1, 0, 0), 100);
      apply(mk(0, 0, JMP, 0, 1, 16'h0000, 26'h0400000, 32'h0100_0000, 0, 0, 0), 101);
      apply(mk(0, 0, JMP, 0, 1, 16'h0000, 26'h0800000, 32'h0200_0000, 0, 0, 0), 102);
      apply(mk(0, 0, SEQ, 0, 0, 16'h0000, 26'h0,       32'h0200_0004, 0, 0, 0), 103);
      apply(mk(0, 0, RET, 0, 0, 16'h0000, 26'h0,       32'h0100_0004, 0, 0, 0), 104);
      apply(mk(0, 0, BR,  1, 0, 16'h0001, 26'h0,       32'h0100_000C, 0, 0, 0), 105);
      apply(mk(0, 0, RET, 0, 0, 16'h0000, 26'h0,       32'h0040_0004, 1, 0, 0), 106);

      // Reset mid-stack, then a full-depth push burst must read back newest first.
      apply(mk(1, 0, SEQ, 0, 0, 16'h0000, 26'h0,       32'h0040_0000, 1, 0, 0), 200);
      for (int k = 1; k <= 4; k++)
         apply(mk(0, 0, JMP, 0, 1, 16'h0000, 26'(k * 32'h0010_0000),
                  32'(k) << 22, 0, (k == 4), 0), 200 + k);
      for (int k = 4; k >= 1; k--)
         apply(mk(0, 0, RET, 0, 0, 16'h0000, 26'h0,
                  (k == 1) ? 32'h0040_0004 : ((32'(k - 1) << 22) + 32'd4),
                  (k == 1), 0, 0), 210 + k);

      if (exp_q.size() != 0) begin
         n_miss++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
